// File: rtl/sa_column_drain.sv
// Drain stage for one column of output-stationary PEs: snapshots the column's
// accumulators, clears the PEs, then streams the snapshot out row by row.
module sa_column_drain #(
  parameter int ROWS  = 8,
  parameter int OC_W  = 48,
  parameter int IDX_W = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS*OC_W-1:0] c_col,
  input  logic                 drain_start,
  output logic                 pe_reg_clear,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [OC_W-1:0]      o_data,
  output logic [IDX_W-1:0]     o_row,
  output logic                 o_last,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun_err
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             clear_q, clear_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [OC_W-1:0]  buf_q [ROWS];

  logic handshake, final_hs, capture, drop;

  assign handshake = (state_q == DRAIN) && o_ready;
  assign final_hs  = handshake && (idx_q == LAST_IDX);
  // A start is accepted when idle or exactly on the final handshake of a tile.
  assign capture   = drain_start && ((state_q == IDLE) || final_hs);
  assign drop      = drain_start && (state_q == DRAIN) && !final_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      clear_q <= clear_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Snapshot storage needs no reset: o_data is masked whenever it is stale.
  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_snap
      always_ff @(posedge clk) begin
        if (capture) begin
          buf_q[gi] <= c_col[gi*OC_W +: OC_W];
        end
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clear_d = capture;
    done_d  = final_hs;
    err_d   = err_q | drop;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = DRAIN;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        if (final_hs) begin
          idx_d   = '0;
          state_d = capture ? DRAIN : IDLE;
        end else if (handshake) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    o_valid      = 1'b0;
    o_data       = '0;
    o_row        = idx_q;
    o_last       = 1'b0;
    busy         = 1'b0;
    pe_reg_clear = clear_q;
    done         = done_q;
    overrun_err  = err_q;
    if (state_q == DRAIN) begin
      o_valid = 1'b1;
      o_data  = buf_q[idx_q];
      o_last  = (idx_q == LAST_IDX);
      busy    = 1'b1;
    end
  end

endmodule

// File: tb/tb_sa_column_drain.sv
// Directed bench for sa_column_drain with ROWS=4, OC_W=48: basic drain,
// backpressure, back-to-back, overrun, mid-drain reset and idle quiescence.
module tb_sa_column_drain;
  localparam int ROWS  = 4;
  localparam int OC_W  = 48;
  localparam int IDX_W = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [ROWS*OC_W-1:0] c_col;
  logic                 drain_start;
  logic                 pe_reg_clear;
  logic                 o_valid;
  logic                 o_ready;
  logic [OC_W-1:0]      o_data;
  logic [IDX_W-1:0]     o_row;
  logic                 o_last;
  logic                 busy;
  logic                 done;
  logic                 overrun_err;

  int n_total = 0;
  int n_bad   = 0;

  sa_column_drain #(.ROWS(ROWS), .OC_W(OC_W), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .c_col        (c_col),
    .drain_start  (drain_start),
    .pe_reg_clear (pe_reg_clear),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .o_data       (o_data),
    .o_row        (o_row),
    .o_last       (o_last),
    .busy         (busy),
    .done         (done),
    .overrun_err  (overrun_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then examined 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ROWS*OC_W-1:0] build(input logic [OC_W-1:0] base);
    logic [ROWS*OC_W-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++) v[r*OC_W +: OC_W] = base + OC_W'(r);
    return v;
  endfunction

  task automatic chk_beat(input string tag, input logic [OC_W-1:0] base, input int r);
    chk({tag, ".valid"}, 64'(o_valid), 64'd1);
    chk({tag, ".data"},  64'(o_data), 64'(base + OC_W'(r)));
    chk({tag, ".row"},   64'(o_row), 64'(r));
    chk({tag, ".last"},  64'(o_last), 64'(r == ROWS - 1));
    chk({tag, ".busy"},  64'(busy), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic ready_seq [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int hs;
    rst = 1'b1; c_col = '0; drain_start = 1'b0; o_ready = 1'b0;
    do_reset();
    tick();
    chk("rst.valid", 64'(o_valid), 64'd0);
    chk("rst.clear", 64'(pe_reg_clear), 64'd0);
    chk("rst.done",  64'(done), 64'd0);
    chk("rst.err",   64'(overrun_err), 64'd0);
    chk("rst.busy",  64'(busy), 64'd0);
    chk("rst.data",  64'(o_data), 64'd0);

    // Basic drain with o_ready held high
    c_col = build(48'h1000); o_ready = 1'b1; drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    chk("basic.clear0", 64'(pe_reg_clear), 64'd1);
    chk("basic.done0",  64'(done), 64'd0);
    chk_beat("basic.b0", 48'h1000, 0);
    for (int r = 1; r < ROWS; r++) begin
      tick();
      chk("basic.clear", 64'(pe_reg_clear), 64'd0);
      chk("basic.done",  64'(done), 64'd0);
      chk_beat("basic.b", 48'h1000, r);
    end
    tick();
    chk("basic.done_end",  64'(done), 64'd1);
    chk("basic.busy_end",  64'(busy), 64'd0);
    chk("basic.valid_end", 64'(o_valid), 64'd0);
    chk("basic.data_end",  64'(o_data), 64'd0);
    tick();
    chk("basic.done_off",  64'(done), 64'd0);

    // Backpressure
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    hs = 0;
    for (int k = 0; k < 7; k++) begin
      chk_beat("bp.beat", 48'h1000, hs);
      chk("bp.done", 64'(done), 64'd0);
      o_ready = ready_seq[k];
      tick();
      if (ready_seq[k]) hs++;
    end
    chk("bp.hs_count", 64'(hs), 64'd4);
    chk("bp.done_end", 64'(done), 64'd1);
    chk("bp.busy_end", 64'(busy), 64'd0);
    o_ready = 1'b1;
    tick();

    // Back-to-back: new start on the final handshake
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    tick(); tick(); tick();
    chk_beat("b2b.last", 48'h1000, 3);
    c_col = build(48'h2000); drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    chk_beat("b2b.new0", 48'h2000, 0);
    chk("b2b.done",  64'(done), 64'd1);
    chk("b2b.clear", 64'(pe_reg_clear), 64'd1);
    chk("b2b.err",   64'(overrun_err), 64'd0);
    for (int r = 1; r < ROWS; r++) begin
      tick();
      chk("b2b.done_off", 64'(done), 64'd0);
      chk_beat("b2b.b", 48'h2000, r);
    end
    tick();
    chk("b2b.done_end", 64'(done), 64'd1);
    chk("b2b.busy_end", 64'(busy), 64'd0);

    // Overrun: start during beat 1 is dropped
    c_col = build(48'h1000); drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    tick();
    chk_beat("ovr.b1", 48'h1000, 1);
    c_col = build(48'h3000); drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    chk("ovr.err1", 64'(overrun_err), 64'd1);
    chk("ovr.clear", 64'(pe_reg_clear), 64'd0);
    chk_beat("ovr.b2", 48'h1000, 2);
    tick();
    chk("ovr.err2", 64'(overrun_err), 64'd1);
    chk_beat("ovr.b3", 48'h1000, 3);
    tick();
    chk("ovr.done", 64'(done), 64'd1);
    for (int k = 0; k < 5; k++) tick();
    chk("ovr.sticky", 64'(overrun_err), 64'd1);
    do_reset();
    tick();
    chk("ovr.cleared", 64'(overrun_err), 64'd0);

    // Reset mid-drain
    c_col = build(48'h1000); drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    tick(); tick();
    chk_beat("mrst.b2", 48'h1000, 2);
    rst = 1'b1;
    tick();
    chk("mrst.valid", 64'(o_valid), 64'd0);
    chk("mrst.data",  64'(o_data), 64'd0);
    chk("mrst.busy",  64'(busy), 64'd0);
    chk("mrst.done",  64'(done), 64'd0);
    rst = 1'b0;
    tick();
    chk("mrst.done2",  64'(done), 64'd0);
    chk("mrst.clear2", 64'(pe_reg_clear), 64'd0);
    c_col = build(48'h4000); drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    chk("mrst.clear", 64'(pe_reg_clear), 64'd1);
    for (int r = 0; r < ROWS; r++) begin
      if (r > 0) tick();
      chk_beat("mrst.b", 48'h4000, r);
    end
    tick();
    chk("mrst.done_end", 64'(done), 64'd1);
    tick();

    // Idle quiescence with random o_ready
    c_col = build(48'h5000);
    for (int k = 0; k < 50; k++) begin
      o_ready = 1'($urandom_range(0, 1));
      tick();
      chk("idle.valid", 64'(o_valid), 64'd0);
      chk("idle.clear", 64'(pe_reg_clear), 64'd0);
      chk("idle.done",  64'(done), 64'd0);
      chk("idle.data",  64'(o_data), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
